// File: rtl/wfifo_wr_arb_pkg.sv
// Shared definitions for the write-port arbiter: FSM encoding and small
// elaboration/decode helpers.
package wfifo_wr_arb_pkg;

  // Widest requester vector the one-hot helper has to cover.
  localparam int unsigned MAX_N = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1 so that derived vectors stay legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // One-hot decode of idx, limited to the low n bits.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx,
                                              input int unsigned n);
    logic [MAX_N-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      oh[i] = (i == idx) && (i < n);
    end
    return oh;
  endfunction

endpackage

// File: rtl/wfifo_wr_arb_rr_arb_pick.sv
// Combinational round-robin priority encoder: first set request bit found
// scanning upward from start_i, wrapping at N.
module rr_arb_pick
  import wfifo_wr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] pos;

  // Scan N positions from the start index; the first hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(start_i) + k) % N);
      if (!found_o && req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/wfifo_wr_arb.sv
// Round-robin arbiter sharing the async FIFO write port between N local
// requesters. One owner at a time writes up to BURST beats; on release the
// next owner is chosen in the same cycle so handoff has no idle cycle.
module wfifo_wr_arb
  import wfifo_wr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            wfull,
  output logic            winc,
  output logic [DW-1:0]   wdata,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int IW = clog2(N);
  localparam int CW = clog2(BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          busy_q, busy_d;

  logic [IW-1:0] own_inc;
  logic [IW-1:0] pick_start;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          own_valid;
  logic          rel;
  logic [N-1:0]  own_oh;

  // Successor of the current owner, wrapping at N.
  always_comb begin
    own_inc = (own_q == IW'(N - 1)) ? '0 : own_q + 1'b1;
  end

  // One picker serves both paths: IDLE scans from rr, a release scans from
  // own+1 so the outgoing owner is considered last.
  always_comb begin
    pick_start = (state_q == ST_GRANT) ? own_inc : rr_q;
  end

  rr_arb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (req_valid),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Write-port outputs: combinational from owner state, requests and wfull.
  always_comb begin
    own_valid = req_valid[own_q];
    own_oh    = N'(onehot(32'(own_q), N));
    winc      = 1'b0;
    req_ready = '0;
    wdata     = '0;
    if (state_q == ST_GRANT) begin
      wdata = req_data[32'(own_q)*DW +: DW];
      if (!wfull) begin
        req_ready = own_oh;
        winc      = own_valid;
      end
    end
  end

  // Next-state: arbitration, beat counting, release and handoff.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          own_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        // A wfull stall keeps winc low, so only a dropped valid can release.
        rel = !own_valid || (winc && (cnt_q == CNT_LAST));
        if (rel) begin
          rr_d  = own_inc;
          cnt_d = '0;
          if (pick_found) begin
            own_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (winc) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    grant_d = '0;
    if (state_d == ST_GRANT) begin
      grant_d = N'(onehot(32'(own_d), N));
    end
    busy_d = (state_d == ST_GRANT);
  end

  // State, owner, pointer, counter and registered status outputs.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_wfifo_wr_arb.sv
// Scoreboard bench for wfifo_wr_arb: requester queues feed the DUT, expected
// (grant, wdata) per written beat are queued and checked on every winc.
module tb_wfifo_wr_arb;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic            wclk;
  logic            wrst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wfull;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic [N-1:0]    grant;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] sb[$];
  logic [7:0]  mem [N][32];
  int          head [N];
  int          tail [N];

  wfifo_wr_arb #(
    .N     (N),
    .DW    (DW),
    .BURST (BURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (head[i] < tail[i]);
      req_data[i*DW +: DW] = (head[i] < tail[i]) ? mem[i][head[i]] : 8'h00;
    end
  endtask

  task automatic load(input int r, input logic [7:0] d);
    mem[r][tail[r]] = d;
    tail[r]++;
  endtask

  task automatic expect_beat(input logic [3:0] g, input logic [7:0] d);
    sb.push_back({g, d});
  endtask

  task automatic flush_reqs();
    for (int i = 0; i < N; i++) head[i] = tail[i];
    drive();
  endtask

  // One clock: capture handshakes mid-cycle, advance queues after the edge.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge wclk);
    acc = req_ready & req_valid;
    @(posedge wclk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) head[i]++;
    drive();
    #1;
  endtask

  task automatic rst_pulse();
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
  endtask

  // Monitor: every written beat must match the next expected entry.
  always @(negedge wclk) begin : monitor
    logic [11:0] e;
    if (wrst_n && winc) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_winc: got grant=%b wdata=%h expected no write", grant, wdata);
      end else begin
        e = sb.pop_front();
        check("beat_grant", 32'(grant), 32'(e[11:8]));
        check("beat_wdata", 32'(wdata), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    // Reset state
    repeat (2) @(posedge wclk);
    #2;
    check("rst_winc",  32'(winc), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_wdata", 32'(wdata), 0);
    wrst_n = 1'b1;

    // Single requester, 6 beats, self re-grant at the burst boundary
    for (int k = 0; k < 6; k++) begin
      load(2, 8'h20 + 8'(k));
      expect_beat(4'b0100, 8'h20 + 8'(k));
    end
    drive();
    step();
    check("t2_grant", 32'(grant), 32'b0100);
    check("t2_busy",  32'(busy), 1);
    for (int k = 0; k < 6; k++) begin
      check("t2_winc", 32'(winc), 1);
      step();
    end
    check("t2_drop_winc", 32'(winc), 0);
    step();
    check("t2_idle_grant", 32'(grant), 0);
    check("t2_idle_busy",  32'(busy), 0);

    // All four requesters: 0,1,2,3 then 0 again, 20 back-to-back beats
    rst_pulse();
    for (int k = 0; k < 8; k++) load(0, 8'h00 + 8'(k));
    for (int r = 1; r < 4; r++)
      for (int k = 0; k < 4; k++) load(r, 8'(r*16 + k));
    for (int k = 0; k < 4; k++) expect_beat(4'b0001, 8'h00 + 8'(k));
    for (int k = 0; k < 4; k++) expect_beat(4'b0010, 8'h10 + 8'(k));
    for (int k = 0; k < 4; k++) expect_beat(4'b0100, 8'h20 + 8'(k));
    for (int k = 0; k < 4; k++) expect_beat(4'b1000, 8'h30 + 8'(k));
    for (int k = 4; k < 8; k++) expect_beat(4'b0001, 8'h00 + 8'(k));
    drive();
    step();
    for (int k = 0; k < 20; k++) begin
      check("t3_winc", 32'(winc), 1);
      step();
    end
    check("t3_drop_winc", 32'(winc), 0);
    step();
    check("t3_idle_busy", 32'(busy), 0);

    // Stall: rr now points at 1
    for (int k = 0; k < 4; k++) begin
      load(1, 8'h50 + 8'(k));
      expect_beat(4'b0010, 8'h50 + 8'(k));
    end
    load(2, 8'h60);
    expect_beat(4'b0100, 8'h60);
    drive();
    step();
    check("t4_grant", 32'(grant), 32'b0010);
    check("t4_winc", 32'(winc), 1);
    step();
    check("t4_winc", 32'(winc), 1);
    step();
    for (int k = 0; k < 3; k++) begin
      wfull = 1'b1;
      #1;
      check("t4_stall_winc",  32'(winc), 0);
      check("t4_stall_ready", 32'(req_ready), 0);
      check("t4_stall_grant", 32'(grant), 32'b0010);
      step();
    end
    wfull = 1'b0;
    #1;
    check("t4_resume_winc", 32'(winc), 1);
    step();
    check("t4_resume_winc", 32'(winc), 1);
    step();
    check("t4_rot_grant", 32'(grant), 32'b0100);
    check("t4_rot_winc", 32'(winc), 1);
    step();
    step();

    // Early release: owner 0 leaves after 2 beats, 1 and 3 waiting
    rst_pulse();
    load(0, 8'h70); load(0, 8'h71);
    expect_beat(4'b0001, 8'h70); expect_beat(4'b0001, 8'h71);
    for (int k = 0; k < 4; k++) begin
      load(1, 8'h80 + 8'(k));
      expect_beat(4'b0010, 8'h80 + 8'(k));
    end
    load(3, 8'h90); load(3, 8'h91);
    expect_beat(4'b1000, 8'h90); expect_beat(4'b1000, 8'h91);
    drive();
    step();
    check("t5_winc", 32'(winc), 1);
    step();
    check("t5_winc", 32'(winc), 1);
    step();
    check("t5_drop_grant", 32'(grant), 32'b0001);
    check("t5_drop_winc",  32'(winc), 0);
    step();
    check("t5_handoff_grant", 32'(grant), 32'b0010);
    check("t5_handoff_winc",  32'(winc), 1);
    step();
    for (int k = 0; k < 3; k++) begin
      check("t5_winc", 32'(winc), 1);
      step();
    end
    check("t5_next_grant", 32'(grant), 32'b1000);
    check("t5_next_winc",  32'(winc), 1);
    step();
    check("t5_winc", 32'(winc), 1);
    step();
    step();

    // Data path from requester 3
    check("t6_idle_wdata", 32'(wdata), 0);
    load(3, 8'hA5); load(3, 8'h5A);
    expect_beat(4'b1000, 8'hA5); expect_beat(4'b1000, 8'h5A);
    drive();
    step();
    check("t6_wdata0", 32'(wdata), 32'hA5);
    step();
    check("t6_wdata1", 32'(wdata), 32'h5A);
    step();
    step();
    check("t6_idle_wdata_after", 32'(wdata), 0);

    // Reset mid-burst: rr is non-zero at the time of reset
    for (int k = 0; k < 5; k++) load(2, 8'hB0 + 8'(k));
    for (int k = 0; k < 4; k++) expect_beat(4'b0100, 8'hB0 + 8'(k));
    drive();
    step();
    for (int k = 0; k < 4; k++) begin
      check("t7_winc", 32'(winc), 1);
      step();
    end
    wrst_n = 1'b0;
    #1;
    check("t7_rst_winc",  32'(winc), 0);
    check("t7_rst_ready", 32'(req_ready), 0);
    check("t7_rst_grant", 32'(grant), 0);
    check("t7_rst_busy",  32'(busy), 0);
    check("t7_rst_wdata", 32'(wdata), 0);
    flush_reqs();
    step();
    wrst_n = 1'b1;
    load(1, 8'hC1);
    load(3, 8'hC3);
    expect_beat(4'b0010, 8'hC1);
    expect_beat(4'b1000, 8'hC3);
    drive();
    step();
    check("t7_post_grant", 32'(grant), 32'b0010);
    repeat (5) step();
    check("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
